serial_bit_feeder: RTL and testbench
====================================

# serial_bit_feeder

Parallel-in, serial-out bit feeder that sits directly upstream of the Moore sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and presents them one bit per clock on a registered serial output that drives the detector's d_in. A one-word holding register lets the producer queue the next word while the current one shifts, so back-to-back words stream with no gap bits.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first
- IDLE_BIT, 0, value driven on d_out when no word is being shifted

- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous, active-high; clears all state immediately
- word_in  input  WIDTH  parallel word from the producer
- word_valid  input  1  word_in is valid
- word_ready  output  1  the block can accept a word; equals !hold_full (combinational from a register)
- d_out  output  1  registered serial bit; connects to the detector's d_in
- bit_valid  output  1  registered; d_out carries a data bit this cycle
- last_bit  output  1  registered; d_out carries the final bit of the current word
- busy  output  1  registered; shifter active or holding register full

## Operation
- Accept occurs at a rising edge where word_valid && word_ready.
- Internal state:
  - WIDTH-bit shift register sh
  - bit counter cnt, $clog2(WIDTH) bits
  - holding register hold with flag hold_full
  - FSM with states IDLE and SHIFT
- IDLE:
  - bit_valid=0, d_out=IDLE_BIT, last_bit=0.
  - On accept: load the word into sh, cnt=0, go to SHIFT. hold stays empty.
- SHIFT, cnt < WIDTH-1:
  - Each edge advances one bit and increments cnt.
  - On accept: the word goes into hold and hold_full=1.
- SHIFT, cnt == WIDTH-1 (last bit on d_out), priority in this order:
  - hold_full: move hold into sh, cnt=0, clear hold_full, stay in SHIFT. word_ready is 0, so no accept is possible on this edge.
  - else accept on this edge: load the word directly into sh, cnt=0, stay in SHIFT.
  - else: go to IDLE.
- Bit order: MSB_FIRST=1 sends word[WIDTH-1] down to word[0]; MSB_FIRST=0 sends word[0] up to word[WIDTH-1].
- The counter never wraps past WIDTH-1. It resets to 0 on every load.
- busy = (state==SHIFT) || hold_full, registered.
- word_in is sampled only on an accept edge. It is don't-care at all other times.
- Reset, including in the middle of a word: all state clears immediately and any partial word and held word are discarded. The output values after reset are:
  - d_out=IDLE_BIT
  - bit_valid=0
  - last_bit=0
  - busy=0
  - word_ready=1
  - FSM in IDLE, cnt=0, hold_full=0
- rst deasserted with word_valid=1: the first accept occurs at the first rising edge after deassertion.

## Timing
- Latency: a word accepted at edge k puts its first bit on d_out after edge k. The detector samples that bit at edge k+1.
- Each bit is held exactly one clock cycle.
- last_bit is high for exactly one cycle per word, aligned with the final bit.
- Back-to-back streaming: the first bit of word N+1 directly follows the last bit of word N with no IDLE_BIT gap, provided word N+1 was accepted no later than the last-bit edge of word N.
- Sustained throughput is 1 word per WIDTH cycles. word_ready stays low from the edge where hold fills until the edge where hold moves into sh.
- Simultaneous accept and hold-to-shifter transfer cannot occur, because word_ready=0 whenever hold_full=1.
- All outputs except word_ready are glitch-free registers. word_ready is a direct function of a flop.

## Test plan
- Reset check: assert rst for 2 cycles with word_valid=1 -> during reset d_out=0, bit_valid=0, busy=0, word_ready=1, and no word is accepted.
- Single word, WIDTH=8, MSB_FIRST=1, word 8'hB4 -> d_out sequence 1,0,1,1,0,1,0,0 on 8 consecutive cycles. bit_valid is high for exactly those 8 cycles and last_bit on the 8th. Then d_out=0 and bit_valid=0.
- Back-to-back: 8'hB4 then 8'h2D, with word_valid held high -> 16 contiguous valid bits 10110100 00101101 with no gap. word_ready drops one cycle after the first accept and rises after the hold-to-shifter transfer.
- LSB first, MSB_FIRST=0, word 8'h01 -> d_out sequence 1,0,0,0,0,0,0,0.
- Late producer: the second word is offered 3 cycles after the first word's last bit -> 3 cycles of IDLE_BIT with bit_valid=0, then a clean restart with cnt=0.
- Reset mid-word: assert rst after the 3rd bit of 8'hFF while 8'h0F is held -> outputs clear immediately. After release with no new word, the block stays IDLE and neither remaining bits nor the held word are ever emitted.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-in serial-out feeder with a one-word holding register
//   clk, rst (async, active-high) ; word_in/word_valid/word_ready : producer handshake
//   d_out : registered serial bit ; bit_valid/last_bit : framing of d_out ; busy : shifting or word held
module serial_bit_feeder #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             d_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, hold_q, hold_d, sh_adv;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hold_full_q, hold_full_d, accept, at_last;
  assign word_ready = !hold_full_q;
  assign accept     = word_valid && word_ready;
  assign at_last    = cnt_q == LAST;
  // the bit on d_out always sits at the outgoing end of sh
  assign sh_adv = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (state_q == IDLE) begin
      if (accept) begin
        sh_d    = word_in;
        cnt_d   = '0;
        state_d = SHIFT;
      end
    end else if (!at_last) begin
      sh_d  = sh_adv;
      cnt_d = cnt_q + CW'(1);
      if (accept) begin
        hold_d      = word_in;
        hold_full_d = 1'b1;
      end
    end else if (hold_full_q) begin
      sh_d        = hold_q;
      cnt_d       = '0;
      hold_full_d = 1'b0;
    end else if (accept) begin
      sh_d  = word_in;
      cnt_d = '0;
    end else begin
      cnt_d   = '0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      d_out       <= IDLE_BIT;
      bit_valid   <= 1'b0;
      last_bit    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      // outputs are registered from next-state so they line up with sh/cnt
      d_out       <= (state_d == SHIFT) ? (MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0]) : IDLE_BIT;
      bit_valid   <= state_d == SHIFT;
      last_bit    <= (state_d == SHIFT) && (cnt_d == LAST);
      busy        <= (state_d == SHIFT) || hold_full_d;
    end
  end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: checks MSB-first and LSB-first feeders against a timeline model
module tb_serial_bit_feeder;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic word_valid = 1'b1;
  logic [W-1:0] word_in = 8'hAA;
  logic ready1, d1, bv1, lb1, busy1;
  logic ready0, d0, bv0, lb0, busy0;
  always #5 clk = ~clk;
  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .word_ready(ready1),
    .d_out(d1), .bit_valid(bv1), .last_bit(lb1), .busy(busy1));
  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid), .word_ready(ready0),
    .d_out(d0), .bit_valid(bv0), .last_bit(lb0), .busy(busy0));
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int nw = 0;
  logic [W-1:0] mw[64];
  int ms[64];
  int me[64];
  bit acc = 1'b0;
  logic [31:0] rec1 = '0;
  logic [31:0] rec0 = '0;
  int recn = 0;
  int gap = 0;
  int last_gap = 0;
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask
  // timeline model: a word accepted at edge k occupies cycles [s, s+W-1], s = max(k, previous end + 1)
  function automatic int start_for(int k);
    return (nw > 0 && me[nw-1] + 1 > k) ? me[nw-1] + 1 : k;
  endfunction
  function automatic bit ready_at(int n);
    for (int i = 0; i < nw; i++) if (ms[i] > n) return 1'b0;
    return 1'b1;
  endfunction
  function automatic bit busy_at(int n);
    for (int i = 0; i < nw; i++) if (me[i] >= n) return 1'b1;
    return 1'b0;
  endfunction
  function automatic int widx(int n);
    for (int i = 0; i < nw; i++) if (ms[i] <= n && n <= me[i]) return i;
    return -1;
  endfunction
  function automatic int e_ready();
    return rst ? 1 : int'(ready_at(cyc));
  endfunction
  function automatic int e_busy();
    return rst ? 0 : int'(busy_at(cyc));
  endfunction
  function automatic int e_bv();
    return (!rst && widx(cyc) >= 0) ? 1 : 0;
  endfunction
  function automatic int e_lb();
    int i = widx(cyc);
    return (!rst && i >= 0 && cyc == me[i]) ? 1 : 0;
  endfunction
  function automatic int e_bit(bit msb);
    int i = widx(cyc);
    if (rst || i < 0) return 0;
    return msb ? int'(mw[i][W-1-(cyc-ms[i])]) : int'(mw[i][cyc-ms[i]]);
  endfunction
  always @(posedge clk) begin
    acc <= 1'b0;
    if (rst) begin
      nw  <= 0;
      cyc <= 0;
    end else begin
      if (word_valid && ready_at(cyc)) begin
        mw[nw] <= word_in;
        ms[nw] <= start_for(cyc + 1);
        me[nw] <= start_for(cyc + 1) + W - 1;
        nw     <= nw + 1;
        acc    <= 1'b1;
      end
      cyc <= cyc + 1;
    end
  end
  always @(negedge clk) begin
    chk("word_ready_msb", ready1, e_ready());
    chk("word_ready_lsb", ready0, e_ready());
    chk("busy_msb", busy1, e_busy());
    chk("busy_lsb", busy0, e_busy());
    chk("bit_valid_msb", bv1, e_bv());
    chk("bit_valid_lsb", bv0, e_bv());
    chk("last_bit_msb", lb1, e_lb());
    chk("last_bit_lsb", lb0, e_lb());
    chk("d_out_msb", d1, e_bit(1'b1));
    chk("d_out_lsb", d0, e_bit(1'b0));
    if (bv1) begin
      rec1 <= {rec1[30:0], d1};
      recn <= recn + 1;
    end
    if (bv0) rec0 <= {rec0[30:0], d0};
    gap <= bv1 ? 0 : gap + 1;
    if (bv1 && gap != 0) last_gap <= gap;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic [W-1:0] w);
    word_in    = w;
    word_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (acc) return;
    end
    chk("accept_timeout", 0, 1);
  endtask
  task automatic wait_idle();
    for (int t = 0; t < 60; t++) begin
      if (!busy_at(cyc)) return;
      tick();
    end
    chk("idle_timeout", 0, 1);
  endtask
  int base;
  initial begin
    tick();
    tick();
    chk("reset_ready_lit", ready1, 1);
    chk("reset_busy_lit", busy1, 0);
    rst = 1'b0;
    send(8'hAA);
    word_valid = 1'b0;
    chk("first_accept_edge", cyc, 1);
    wait_idle();
    base = recn;
    send(8'hB4);
    word_valid = 1'b0;
    wait_idle();
    tick();
    tick();
    chk("single_count", recn - base, 8);
    chk("single_msb_stream", int'(rec1[7:0]), 8'hB4);
    chk("single_lsb_stream", int'(rec0[7:0]), 8'h2D);
    base = recn;
    send(8'hB4);
    send(8'h2D);
    word_valid = 1'b0;
    wait_idle();
    tick();
    chk("b2b_count", recn - base, 16);
    chk("b2b_msb_stream", int'(rec1[15:0]), 16'hB42D);
    chk("b2b_lsb_stream", int'(rec0[15:0]), 16'h2DB4);
    send(8'h01);
    word_valid = 1'b0;
    wait_idle();
    tick();
    chk("lsb01_lsb_stream", int'(rec0[7:0]), 8'h80);
    chk("lsb01_msb_stream", int'(rec1[7:0]), 8'h01);
    send(8'hA5);
    word_valid = 1'b0;
    wait_idle();
    tick();
    tick();
    send(8'hC3);
    word_valid = 1'b0;
    wait_idle();
    tick();
    chk("late_gap", last_gap, 3);
    chk("late_stream", int'(rec1[15:0]), 16'hA5C3);
    base = recn;
    send(8'hFF);
    send(8'h0F);
    word_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midreset_d_out", d1, 0);
    chk("midreset_bit_valid", bv1, 0);
    chk("midreset_busy", busy1, 0);
    chk("midreset_ready", ready1, 1);
    tick();
    tick();
    rst = 1'b0;
    for (int t = 0; t < 20; t++) tick();
    chk("midreset_count", recn - base, 3);
    chk("midreset_bits", int'(rec1[2:0]), 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
